reg_stage: RTL and testbench
============================

// Module: reg_stage
// PURPOSE
//  Register-read stage directly upstream of the ALU. Holds the architectural register file,
//  reads operands for the decoded instruction and emits reg_to_alu_req_o.
//  Accepts writeback from the WB stage and tracks in-flight destinations in a scoreboard.
//  Stalls the decoder on RAW/WAW hazards and inserts bubbles (op_none) toward the ALU.
// PARAMETERS
//  NUM_REGS    16  architectural registers; reg_t index width = $clog2(NUM_REGS)
//  RESET_VAL   0   reset value of every register-file entry (imm_t)
// PORTS
//  clk               in   1      clock; all state updates on rising edge
//  rst               in   1      reset, synchronous, active-high
//  dec_to_reg_req_i  in   struct valid, alu_s1_font, alu_opcode, reg_src_1, reg_src_2, imm, fur_sig
//  wb_to_reg_req_i   in   struct wr_en, reg_dst (reg_t), data (imm_t)
//  reg_stall_o       out  1      decoder must hold current instruction
//  reg_to_alu_req_o  out  struct alu_s1_font, alu_opcode, src_1, src_2, src_3, fur_sig
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-high.
//  Reset: all RF entries := RESET_VAL; scoreboard := all 0.
//   - reg_stall_o = 0 while rst is high.
//   - reg_to_alu_req_o = bubble while rst is high.
//  Bubble: alu_opcode=op_none, alu_s1_font=font_reg, src_1/2/3=0, fur_sig.wb_wr=0, reg_dst=0, pc_branch=0.
//  Outputs are combinational from RF/scoreboard state; the ALU registers them (1-cycle issue).
//  Hazard check, only when dec valid:
//   - raw1 = pend[reg_src_1] & ~clr1
//   - raw2 = pend[reg_src_2] & ~clr2
//   - waw  = fur_sig.wb_wr & pend[reg_dst] & ~clrd
//   - clrX = same-cycle wb write to that index (see CONFIGURATION).
//   - reg_stall_o = valid & (raw1|raw2|waw).
//   - Sources are checked regardless of opcode; a font_imm move still checks reg_src_1.
//  Issue: valid & ~stall -> output carries:
//   - src_1 = rf[reg_src_1], src_2 = rf[reg_src_2], src_3 = imm.
//   - Other fields are passed through unchanged.
//   - If fur_sig.wb_wr, pend[reg_dst] := 1 next cycle.
//  Not issuing (~valid or stall): output = bubble; scoreboard not set.
//  Writeback: wr_en -> rf[reg_dst] := data and pend[reg_dst] := 0 next edge.
//  Simultaneous set and clear of the same index: set wins (pend stays 1); RF still written.
//  wr_en to an index whose pend=0: RF written, scoreboard unchanged (no error).
//  Reset mid-operation: scoreboard cleared; writebacks arriving during or after rst are ignored until rst deasserts.
//   - Upstream and downstream are flushed by the same rst.
//  Index width: reg_t; NUM_REGS must be a power of two (no out-of-range indices).
// CONFIGURATION
//  REG_BYPASS_EN defined:
//   - Same-cycle wb write to a source index forwards wb data.data into src_1/src_2 and clears that hazard (clrX=1).
//   - Forwarded data takes priority over the stale RF value.
//   - clrd also = 1, so WAW resolves in the same cycle.
//  REG_BYPASS_EN undefined:
//   - clrX = 0; reader stalls until the cycle after the write, then reads the RF.
//   - Costs exactly +1 stall cycle per dependency.
// STRUCTURE
//  reg_pkg:
//   - dec_to_reg_req_t, wb_to_reg_req_t, REG_BUBBLE constant.
//   - reg_t, imm_t, alu_fur_sig_t and the opcode/font enums stay in existing packages.
//  Sub-module reg_scoreboard:
//   - NUM_REGS pending bits; set/clear ports with set-wins priority.
//   - Combinational pend vector output.
//  RF array and bypass muxes live in reg_stage.
// TESTING
//  1 Reset with RESET_VAL=0 -> output = bubble, stall=0; issue "move r1" (font_reg) -> src_1=0.
//  2 Issue add r3<-r1+r2 (wb_wr=1); next cycle issue reader of r3 -> stall=1 and bubble until WB.
//    - WB r3=0x55 with bypass: issue that cycle with src_1=0x55.
//    - WB r3=0x55 without bypass: issue the next cycle with src_1=0x55.
//  3 WAW: in-flight write to r4; issue a second write to r4 -> stall until the first WB; then pend[r4]=1 again.
//  4 Same-cycle set and clear of r5 (WB r5 and issue of a new writer to r5) -> pend[r5]=1; reader of r5 stalls.
//  5 Writeback to r7 with pend=0, data 0xA5 -> later read of r7 gives 0xA5; no stall.
//  6 rst pulse while 3 writes are outstanding -> pend all 0, RF=RESET_VAL, WB during rst ignored, next reader not stalled.

Source files
------------

// File: rtl/core_pkg.sv
// Shared pipeline types: register index/immediate widths, ALU opcode and operand-font
// enums, and the control bundle that travels with each instruction to writeback.
package core_pkg;

    localparam int REG_COUNT = 16;

    typedef logic [$clog2(REG_COUNT)-1:0] reg_t;
    typedef logic [31:0]                  imm_t;

    typedef enum logic [3:0] {
        op_none = 4'd0,
        op_add  = 4'd1,
        op_sub  = 4'd2,
        op_and  = 4'd3,
        op_or   = 4'd4,
        op_xor  = 4'd5,
        op_mov  = 4'd6,
        op_sll  = 4'd7,
        op_srl  = 4'd8,
        op_beq  = 4'd9
    } alu_opcode_t;

    // Selects what the ALU uses as its first operand.
    typedef enum logic [1:0] {
        font_reg = 2'd0,
        font_imm = 2'd1,
        font_pc  = 2'd2
    } alu_s1_font_t;

    typedef struct packed {
        logic wb_wr;
        reg_t reg_dst;
        logic pc_branch;
    } alu_fur_sig_t;

endpackage

// File: rtl/reg_pkg.sv
// Request/response structs for the register-read stage and the bubble it sends
// toward the ALU when nothing issues.
package reg_pkg;
    import core_pkg::*;

    typedef struct packed {
        logic         valid;
        alu_s1_font_t alu_s1_font;
        alu_opcode_t  alu_opcode;
        reg_t         reg_src_1;
        reg_t         reg_src_2;
        imm_t         imm;
        alu_fur_sig_t fur_sig;
    } dec_to_reg_req_t;

    typedef struct packed {
        logic wr_en;
        reg_t reg_dst;
        imm_t data;
    } wb_to_reg_req_t;

    typedef struct packed {
        alu_s1_font_t alu_s1_font;
        alu_opcode_t  alu_opcode;
        imm_t         src_1;
        imm_t         src_2;
        imm_t         src_3;
        alu_fur_sig_t fur_sig;
    } reg_to_alu_req_t;

    localparam reg_to_alu_req_t REG_BUBBLE = '{
        alu_s1_font: font_reg,
        alu_opcode:  op_none,
        src_1:       '0,
        src_2:       '0,
        src_3:       '0,
        fur_sig:     '0
    };

    // True when an enabled write targets the given index.
    function automatic logic idx_hit(input logic en, input reg_t wr_idx, input reg_t rd_idx);
        return en && (wr_idx == rd_idx);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// One pending bit per architectural register; a same-edge set and clear of the
// same index leaves the bit set because the new writer is younger.
module reg_scoreboard
    import core_pkg::*;
#(
    parameter int NUM_REGS = REG_COUNT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  reg_t                set_idx,
    input  logic                clr_en,
    input  reg_t                clr_idx,
    output logic [NUM_REGS-1:0] pend
);

    logic [NUM_REGS-1:0] pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (set_en && (set_idx == reg_t'(i))) begin
                    pend_q[i] <= 1'b1;
                end else if (clr_en && (clr_idx == reg_t'(i))) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/reg_stage.sv
// Register-read stage: register file, hazard detection against in-flight writers,
// and operand issue to the ALU. Define REG_BYPASS_EN to forward same-cycle writeback data.
module reg_stage
    import core_pkg::*;
    import reg_pkg::*;
#(
    parameter int   NUM_REGS  = REG_COUNT,
    parameter imm_t RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  dec_to_reg_req_t dec_to_reg_req_i,
    input  wb_to_reg_req_t  wb_to_reg_req_i,
    output logic            reg_stall_o,
    output reg_to_alu_req_t reg_to_alu_req_o
);

    // Handshake: the decoder presents an instruction with valid=1 and must hold it
    // unchanged while reg_stall_o=1; it is consumed in any cycle where valid=1 and
    // reg_stall_o=0. The ALU side has no back-pressure and registers every cycle.

    dec_to_reg_req_t     dec;
    wb_to_reg_req_t      wb;
    imm_t                rf [NUM_REGS];
    logic [NUM_REGS-1:0] pend;

    logic clr1, clr2, clrd;
    logic raw1, raw2, waw;
    logic hazard;
    logic issue;
    imm_t op1, op2;

    assign dec = dec_to_reg_req_i;
    assign wb  = wb_to_reg_req_i;

`ifdef REG_BYPASS_EN
    assign clr1 = idx_hit(wb.wr_en, wb.reg_dst, dec.reg_src_1);
    assign clr2 = idx_hit(wb.wr_en, wb.reg_dst, dec.reg_src_2);
    assign clrd = idx_hit(wb.wr_en, wb.reg_dst, dec.fur_sig.reg_dst);
`else
    assign clr1 = 1'b0;
    assign clr2 = 1'b0;
    assign clrd = 1'b0;
`endif

    // Sources are checked even when the opcode ignores them, keeping the check opcode-agnostic.
    assign raw1   = pend[dec.reg_src_1] & ~clr1;
    assign raw2   = pend[dec.reg_src_2] & ~clr2;
    assign waw    = dec.fur_sig.wb_wr & pend[dec.fur_sig.reg_dst] & ~clrd;
    assign hazard = raw1 | raw2 | waw;

    assign reg_stall_o = ~rst & dec.valid & hazard;
    assign issue       = ~rst & dec.valid & ~hazard;

    always_comb begin
        op1 = rf[dec.reg_src_1];
        op2 = rf[dec.reg_src_2];
`ifdef REG_BYPASS_EN
        if (clr1) begin
            op1 = wb.data;
        end
        if (clr2) begin
            op2 = wb.data;
        end
`endif
    end

    always_comb begin
        reg_to_alu_req_o = REG_BUBBLE;
        if (issue) begin
            reg_to_alu_req_o.alu_s1_font = dec.alu_s1_font;
            reg_to_alu_req_o.alu_opcode  = dec.alu_opcode;
            reg_to_alu_req_o.src_1       = op1;
            reg_to_alu_req_o.src_2       = op2;
            reg_to_alu_req_o.src_3       = dec.imm;
            reg_to_alu_req_o.fur_sig     = dec.fur_sig;
        end
    end

    // Writebacks seen while rst is high are dropped by the reset branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= RESET_VAL;
            end
        end else if (wb.wr_en) begin
            rf[wb.reg_dst] <= wb.data;
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue & dec.fur_sig.wb_wr),
        .set_idx (dec.fur_sig.reg_dst),
        .clr_en  (wb.wr_en),
        .clr_idx (wb.reg_dst),
        .pend    (pend)
    );

endmodule

// File: tb/tb_reg_stage.sv
// Directed bench for reg_stage: reset, RAW/WAW stalls, set-wins scoreboard,
// stray writeback, mid-run reset. Expectations follow REG_BYPASS_EN if defined.
module tb_reg_stage;
    import core_pkg::*;
    import reg_pkg::*;

    localparam int W = 1 + $bits(reg_to_alu_req_t);
    localparam dec_to_reg_req_t IDLE  = '0;
    localparam wb_to_reg_req_t  NO_WB = '0;

    logic            clk = 1'b0;
    logic            rst;
    dec_to_reg_req_t dec;
    wb_to_reg_req_t  wb;
    logic            stall;
    reg_to_alu_req_t alu;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_stage #(
        .NUM_REGS  (16),
        .RESET_VAL (32'h0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .dec_to_reg_req_i (dec),
        .wb_to_reg_req_i  (wb),
        .reg_stall_o      (stall),
        .reg_to_alu_req_o (alu)
    );

    function automatic dec_to_reg_req_t mk_dec(input alu_opcode_t op, input alu_s1_font_t font,
                                               input reg_t s1, input reg_t s2, input imm_t imm,
                                               input logic wr, input reg_t dst);
        dec_to_reg_req_t d;
        d.valid             = 1'b1;
        d.alu_s1_font       = font;
        d.alu_opcode        = op;
        d.reg_src_1         = s1;
        d.reg_src_2         = s2;
        d.imm               = imm;
        d.fur_sig.wb_wr     = wr;
        d.fur_sig.reg_dst   = dst;
        d.fur_sig.pc_branch = 1'b0;
        return d;
    endfunction

    function automatic wb_to_reg_req_t mk_wb(input reg_t dst, input imm_t data);
        wb_to_reg_req_t w;
        w.wr_en   = 1'b1;
        w.reg_dst = dst;
        w.data    = data;
        return w;
    endfunction

    function automatic reg_to_alu_req_t bubble();
        reg_to_alu_req_t r;
        r.alu_s1_font       = font_reg;
        r.alu_opcode        = op_none;
        r.src_1             = 32'h0;
        r.src_2             = 32'h0;
        r.src_3             = 32'h0;
        r.fur_sig.wb_wr     = 1'b0;
        r.fur_sig.reg_dst   = 4'd0;
        r.fur_sig.pc_branch = 1'b0;
        return r;
    endfunction

    function automatic reg_to_alu_req_t issued(input dec_to_reg_req_t d, input imm_t v1, input imm_t v2);
        reg_to_alu_req_t r;
        r.alu_s1_font = d.alu_s1_font;
        r.alu_opcode  = d.alu_opcode;
        r.src_1       = v1;
        r.src_2       = v2;
        r.src_3       = d.imm;
        r.fur_sig     = d.fur_sig;
        return r;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
    task automatic cyc(input string tag, input dec_to_reg_req_t d, input wb_to_reg_req_t w,
                       input logic exp_stall, input reg_to_alu_req_t exp_out);
        logic [W-1:0]    e;
        reg_to_alu_req_t e_out;
        dec = d;
        wb  = w;
        exp_q.push_back({exp_stall, exp_out});
        @(negedge clk);
        e     = exp_q.pop_front();
        e_out = reg_to_alu_req_t'(e[W-2:0]);
        checks++;
        assert (stall === e[W-1]) else begin
            errors++;
            $error("FAIL %s stall got %0b exp %0b", tag, stall, e[W-1]);
        end
        checks++;
        assert (alu === e_out) else begin
            errors++;
            $error("FAIL %s alu got %h exp %h", tag, alu, e_out);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        dec_to_reg_req_t d;
        dec_to_reg_req_t d2;
        imm_t            rnd;

        rst = 1'b1;
        dec = IDLE;
        wb  = NO_WB;
        repeat (2) @(posedge clk);
        #1;

        // Reset: bubble and no stall even with a valid instruction presented.
        d = mk_dec(op_mov, font_reg, 4'd1, 4'd0, 32'h0, 1'b0, 4'd0);
        cyc("reset_out", d, NO_WB, 1'b0, bubble());
        rst = 1'b0;
        cyc("move_r1", d, NO_WB, 1'b0, issued(d, 32'h0, 32'h0));

        // RAW on r3.
        d = mk_dec(op_add, font_reg, 4'd1, 4'd2, 32'h11, 1'b1, 4'd3);
        cyc("add_r3", d, NO_WB, 1'b0, issued(d, 32'h0, 32'h0));
        d = mk_dec(op_add, font_reg, 4'd3, 4'd0, 32'h0, 1'b1, 4'd6);
        cyc("raw_stall_a", d, NO_WB, 1'b1, bubble());
        cyc("raw_stall_b", d, NO_WB, 1'b1, bubble());
`ifdef REG_BYPASS_EN
        cyc("raw_wb_fwd", d, mk_wb(4'd3, 32'h55), 1'b0, issued(d, 32'h55, 32'h0));
`else
        cyc("raw_wb_cycle", d, mk_wb(4'd3, 32'h55), 1'b1, bubble());
        cyc("raw_after_wb", d, NO_WB, 1'b0, issued(d, 32'h55, 32'h0));
`endif
        cyc("wb_r6", IDLE, mk_wb(4'd6, 32'h66), 1'b0, bubble());

        // WAW on r4.
        d = mk_dec(op_mov, font_imm, 4'd0, 4'd0, 32'h44, 1'b1, 4'd4);
        cyc("wr_r4_first", d, NO_WB, 1'b0, issued(d, 32'h0, 32'h0));
        d2 = mk_dec(op_mov, font_imm, 4'd0, 4'd0, 32'h45, 1'b1, 4'd4);
        cyc("waw_stall", d2, NO_WB, 1'b1, bubble());
`ifdef REG_BYPASS_EN
        cyc("waw_wb_fwd", d2, mk_wb(4'd4, 32'h40), 1'b0, issued(d2, 32'h0, 32'h0));
`else
        cyc("waw_wb_cycle", d2, mk_wb(4'd4, 32'h40), 1'b1, bubble());
        cyc("waw_after_wb", d2, NO_WB, 1'b0, issued(d2, 32'h0, 32'h0));
`endif
        d = mk_dec(op_add, font_reg, 4'd4, 4'd6, 32'h0, 1'b0, 4'd0);
        cyc("r4_pend_again", d, NO_WB, 1'b1, bubble());
        cyc("wb_r4_second", IDLE, mk_wb(4'd4, 32'h41), 1'b0, bubble());
        cyc("read_r4", d, NO_WB, 1'b0, issued(d, 32'h41, 32'h66));

        // Same-edge set and clear of r5: the set must win.
        d = mk_dec(op_sub, font_reg, 4'd0, 4'd0, 32'h5, 1'b1, 4'd5);
        cyc("set_clr_r5", d, mk_wb(4'd5, 32'h50), 1'b0, issued(d, 32'h0, 32'h0));
        d2 = mk_dec(op_add, font_reg, 4'd5, 4'd0, 32'h0, 1'b0, 4'd0);
        cyc("r5_still_pend", d2, NO_WB, 1'b1, bubble());
        cyc("wb_r5", IDLE, mk_wb(4'd5, 32'h5A), 1'b0, bubble());
        cyc("read_r5", d2, NO_WB, 1'b0, issued(d2, 32'h5A, 32'h0));

        // Writeback to a register nobody is waiting on.
        cyc("wb_r7_nopend", IDLE, mk_wb(4'd7, 32'hA5), 1'b0, bubble());
        d = mk_dec(op_and, font_reg, 4'd7, 4'd7, 32'h0, 1'b0, 4'd0);
        cyc("read_r7", d, NO_WB, 1'b0, issued(d, 32'hA5, 32'hA5));

        for (int i = 0; i < 4; i++) begin
            rnd = imm_t'($urandom_range(32'h7FFF_FFFF, 0));
            cyc("wb_rand", IDLE, mk_wb(reg_t'(11 + i), rnd), 1'b0, bubble());
            d = mk_dec(op_xor, font_reg, reg_t'(11 + i), 4'd7, rnd ^ 32'h3, 1'b0, 4'd0);
            cyc("read_rand", d, NO_WB, 1'b0, issued(d, rnd, 32'hA5));
        end

        // Three writers outstanding, then a reset pulse with a writeback in flight.
        for (int i = 0; i < 3; i++) begin
            d = mk_dec(op_add, font_reg, 4'd0, 4'd0, 32'h0, 1'b1, reg_t'(8 + i));
            cyc("wr_outstanding", d, NO_WB, 1'b0, issued(d, 32'h0, 32'h0));
        end
        d = mk_dec(op_add, font_reg, 4'd9, 4'd8, 32'h0, 1'b0, 4'd0);
        rst = 1'b1;
        cyc("rst_mid", d, mk_wb(4'd8, 32'hEE), 1'b0, bubble());
        rst = 1'b0;
        cyc("post_rst_read", d, NO_WB, 1'b0, issued(d, 32'h0, 32'h0));
        d = mk_dec(op_or, font_reg, 4'd7, 4'd10, 32'h0, 1'b1, 4'd10);
        cyc("post_rst_waw", d, NO_WB, 1'b0, issued(d, 32'h0, 32'h0));
        cyc("idle_end", IDLE, NO_WB, 1'b0, bubble());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
